io_request_arbiter: RTL and testbench

IO_REQUEST_ARBITER -- requirements
Module: io_request_arbiter

---
 rtl/io_request_arbiter.sv | 160 ++++++++++++++++
 tb/tb_io_request_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/io_request_arbiter.sv
// io_request_arbiter
//   Round-robin arbiter that funnels per-core non-cacheable read/write requests
//   onto a single device bus, one transaction at a time.
//
// Parameters
//   NUM_CORES       number of requesting cores (power of 2, 2..16)
//   TIMEOUT_CYCLES  bus cycles to wait for bus_ack before forcing completion
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   core_write_en/read_en   per-core request strobes, held until core_done
//   core_address/write_data per-core 32-bit fields packed core i at [32i+31:32i]
//   core_read_data          per-core registered read result, same packing
//   core_done/core_error    one-cycle completion pulse / timeout flag per core
//   bus_*                   device bus strobes, address, data, ack
//   busy                    high whenever a transaction is in flight

module io_request_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CORES-1:0]    core_write_en,
    input  logic [NUM_CORES-1:0]    core_read_en,
    input  logic [NUM_CORES*32-1:0] core_address,
    input  logic [NUM_CORES*32-1:0] core_write_data,
    output logic [NUM_CORES*32-1:0] core_read_data,
    output logic [NUM_CORES-1:0]    core_done,
    output logic [NUM_CORES-1:0]    core_error,
    output logic                    bus_write_en,
    output logic                    bus_read_en,
    output logic [31:0]             bus_address,
    output logic [31:0]             bus_write_data,
    input  logic [31:0]             bus_read_data,
    input  logic                    bus_ack,
    output logic                    busy
);
    localparam int IW = $clog2(NUM_CORES);
    localparam int CW = 16;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                       state, state_nxt;
    logic [IW-1:0]                ptr, gnt;
    logic [31:0]                  lat_addr, lat_data;
    logic                         lat_wr;
    logic [CW-1:0]                cnt;
    logic                         err;

    logic [NUM_CORES-1:0]         req;
    logic [NUM_CORES-1:0][31:0]   addr_v, data_v;
    logic                         arb_vld;
    logic [IW-1:0]                arb_idx, idx;
    logic                         timeout, complete;
    logic [NUM_CORES-1:0]         slot_load;
    logic [31:0]                  slot_din;

    assign req    = core_write_en | core_read_en;
    assign addr_v = core_address;
    assign data_v = core_write_data;

    // Scan from the pointer downward in distance so the nearest requester
    // (smallest offset from ptr) is the last, winning assignment.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        idx     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = ptr + IW'(k);
            if (req[idx]) begin
                arb_vld = 1'b1;
                arb_idx = idx;
            end
        end
    end

    assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign complete = (state == BUS) && (bus_ack || timeout);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld)  state_nxt = BUS;
            BUS:     if (complete) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (arb_vld) begin
                    gnt      <= arb_idx;
                    ptr      <= arb_idx + 1'b1;   // wraps naturally: NUM_CORES is 2^IW
                    lat_addr <= addr_v[arb_idx];
                    lat_data <= data_v[arb_idx];
                    lat_wr   <= core_write_en[arb_idx];
                    cnt      <= '0;
                    err      <= 1'b0;
                end
                BUS: begin
                    cnt <= cnt + 1'b1;
                    // ack wins over a coincident timeout
                    if (bus_ack)      err <= 1'b0;
                    else if (timeout) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read results land in the granted core's slot; timed-out reads return all ones.
    assign slot_din = bus_ack ? bus_read_data : 32'hFFFF_FFFF;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        assign slot_load[i] = complete && !lat_wr && (gnt == IW'(i));
        io_request_arbiter_slot u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (slot_load[i]),
            .din     (slot_din),
            .dout    (core_read_data[32*i +: 32])
        );
    end

    assign busy           = (state != IDLE);
    assign bus_write_en   = (state == BUS) &&  lat_wr;
    assign bus_read_en    = (state == BUS) && !lat_wr;
    assign bus_address    = (state == BUS) ? lat_addr : '0;
    assign bus_write_data = (state == BUS) ? lat_data : '0;
    assign core_done      = (state == DONE)        ? (NUM_CORES'(1) << gnt) : '0;
    assign core_error     = (state == DONE && err) ? (NUM_CORES'(1) << gnt) : '0;

endmodule

// Per-core read-result register: holds until the next read completion for that core.
module io_request_arbiter_slot (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  dout <= '0;
        else if (load) dout <= din;
    end
endmodule

// File: tb/tb_io_request_arbiter.sv
module tb_io_request_arbiter;
    localparam int NC = 4;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NC-1:0]        wr, rd;
    logic [NC-1:0][31:0]  addr, data;
    logic [NC*32-1:0]     core_read_data;
    logic [NC-1:0]        core_done, core_error;
    logic                 bus_write_en, bus_read_en, bus_ack, busy;
    logic [31:0]          bus_address, bus_write_data, bus_read_data;

    io_request_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .core_write_en   (wr),
        .core_read_en    (rd),
        .core_address    (addr),
        .core_write_data (data),
        .core_read_data  (core_read_data),
        .core_done       (core_done),
        .core_error      (core_error),
        .bus_write_en    (bus_write_en),
        .bus_read_en     (bus_read_en),
        .bus_address     (bus_address),
        .bus_write_data  (bus_write_data),
        .bus_read_data   (bus_read_data),
        .bus_ack         (bus_ack),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: round-robin pointer and per-core read slots
    int          m_ptr;
    logic [31:0] m_slot [NC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NC; i++) m_slot[i] = '0;
    endtask

    task automatic chk_slots(input string tag);
        for (int i = 0; i < NC; i++)
            chk($sformatf("%s_slot%0d", tag, i), core_read_data[32*i +: 32], m_slot[i]);
    endtask

    // Called at a negedge with the arbiter idle and requests already driven.
    // ack_at: BUS cycle (1-based) on which the device acks; > TO means never.
    task automatic run_txn(input int ack_at, input logic [31:0] rval,
                           input bit stray, input bit withdraw);
        int          g;
        bit          is_wr, err, fin;
        int          n;
        logic [NC-1:0] onehot;
        g = -1;
        for (int k = 0; k < NC; k++) begin
            int i;
            i = (m_ptr + k) % NC;
            if (g < 0 && (wr[i] || rd[i])) g = i;
        end
        if (g < 0) return;
        is_wr  = wr[g];
        m_ptr  = (g + 1) % NC;
        onehot = NC'(1) << g;

        chk("idle_busy", busy, 0);
        chk("idle_strobe", {bus_write_en, bus_read_en}, 0);
        if (stray) begin
            bus_ack       = 1'b1;
            bus_read_data = $urandom;
        end
        n = 0; fin = 0; err = 0;
        while (!fin) begin
            @(negedge clk);
            bus_ack = 1'b0;
            n++;
            chk("bus_busy", busy, 1);
            chk("bus_wr_en", bus_write_en, is_wr);
            chk("bus_rd_en", bus_read_en, !is_wr);
            chk("bus_addr", bus_address, addr[g]);
            if (is_wr) chk("bus_wdata", bus_write_data, data[g]);
            chk("bus_no_done", core_done, 0);
            if (withdraw && n == 1) begin
                wr[g] = 1'b0;
                rd[g] = 1'b0;
            end
            if (n == ack_at) begin
                bus_ack       = 1'b1;
                bus_read_data = rval;
                fin = 1;
            end else if (n == TO) begin
                fin = 1;
                err = 1;
            end
        end
        @(negedge clk);
        bus_ack       = stray;        // stray ack during DONE must be ignored
        bus_read_data = $urandom;
        chk("done_onehot", core_done, onehot);
        chk("done_error", core_error, err ? onehot : '0);
        chk("done_strobe", {bus_write_en, bus_read_en}, 0);
        chk("done_addr", bus_address, 0);
        chk("done_busy", busy, 1);
        if (!is_wr) m_slot[g] = err ? 32'hFFFF_FFFF : rval;
        wr[g] = 1'b0;
        rd[g] = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("post_busy", busy, 0);
        chk("post_done", core_done, 0);
        chk_slots("post");
    endtask

    task automatic set_req(input int c, input bit w, input bit r,
                           input logic [31:0] a, input logic [31:0] d);
        wr[c] = w; rd[c] = r; addr[c] = a; data[c] = d;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        wr = '0; rd = '0; addr = '0; data = '0;
        bus_ack = 1'b0; bus_read_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", {bus_write_en, bus_read_en}, 0);
        chk("rst_done", {core_done, core_error}, 0);
        chk_slots("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // all four cores at once from a fresh pointer: served 0,1,2,3
        for (int i = 0; i < NC; i++) set_req(i, 0, 1, 32'h100 * i, '0);
        for (int i = 0; i < NC; i++) run_txn(1, 32'h1111_0000 + i, 0, 0);

        // core 2 read, ack on third BUS cycle
        set_req(2, 0, 1, 32'h1000, '0);
        run_txn(3, 32'hDEAD_BEEF, 0, 0);

        // core 1 write+read together: write only, slot untouched
        set_req(1, 1, 1, 32'h20, 32'h55);
        run_txn(2, 32'h0BAD_0BAD, 0, 0);

        // core 0 read with no ack: timeout after TO cycles
        set_req(0, 0, 1, 32'h40, '0);
        run_txn(TO + 5, '0, 0, 0);

        // stray ack in IDLE, then ack coincident with the timeout cycle
        set_req(0, 0, 1, 32'h44, '0);
        run_txn(TO, 32'hCAFE_F00D, 1, 0);

        // reset during BUS of core 3, then re-grant from scratch
        set_req(3, 0, 1, 32'h3000, '0);
        @(posedge clk);
        repeat (2) @(negedge clk);
        chk("pre_rst_rd_en", bus_read_en, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_strobe", {bus_write_en, bus_read_en}, 0);
        chk("midrst_addr", bus_address, 0);
        model_reset();
        chk_slots("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(2, 32'h3333_3333, 0, 0);

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            int ack_at;
            for (int c = 0; c < NC; c++) begin
                if (!(wr[c] || rd[c]) && $urandom_range(0, 9) < 4) begin
                    case ($urandom_range(0, 2))
                        0:       set_req(c, 1, 0, $urandom, $urandom);
                        1:       set_req(c, 0, 1, $urandom, $urandom);
                        default: set_req(c, 1, 1, $urandom, $urandom);
                    endcase
                end
            end
            if ((wr | rd) == '0) set_req($urandom_range(0, NC - 1), 0, 1, $urandom, $urandom);
            ack_at = $urandom_range(1, TO + 2);
            run_txn(ack_at, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
